// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator control path and datapath:
//   - CALC_OP_W    : operator code width
//   - OP_*         : operator encodings, shared with the datapath ALU
//   - calc_state_t : control FSM state encoding
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int CALC_OP_W = 3;

  // Operator encodings understood by the datapath ALU.
  localparam logic [CALC_OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [CALC_OP_W-1:0] OP_SUB  = 3'd1;
  localparam logic [CALC_OP_W-1:0] OP_AND  = 3'd2;
  localparam logic [CALC_OP_W-1:0] OP_OR   = 3'd3;
  localparam logic [CALC_OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [CALC_OP_W-1:0] OP_SHL  = 3'd5;
  localparam logic [CALC_OP_W-1:0] OP_SHR  = 3'd6;
  localparam logic [CALC_OP_W-1:0] OP_PASS = 3'd7;

  // Control sequence: operand A -> operator -> operand B -> execute -> display.
  typedef enum logic [3:0] {
    S_CLR,      // clear all datapath registers
    S_IDLE,     // waiting for operand A
    S_LOAD_A,   // strobe operand A into the input register
    S_XFER_A,   // copy operand A into ACC
    S_WAIT_OP,  // waiting for an operator
    S_LOAD_OP,  // strobe the operator into the opcode register
    S_WAIT_B,   // waiting for operand B
    S_LOAD_B,   // strobe operand B into the input register
    S_WAIT_EQ,  // waiting for equals
    S_EXEC,     // ALU settling, ACC captures in the final cycle
    S_SHOW      // result on display
  } calc_state_t;

endpackage

// File: rtl/calc_control_unit.sv
// -----------------------------------------------------------------------------
// calc_control_unit
// Control FSM for the calculator datapath. Converts single-cycle keypad events
// into datapath strobes. Outputs are a Moore decode of the state register.
//
// Parameters:
//   EXEC_CYCLES  : cycles the ALU result needs before ACC capture (>= 1)
// Build option:
//   CALC_CHAIN_EN : when defined, an operator pressed while the result is on
//                   display starts a new operation with ACC as operand A.
//
// Ports:
//   clk, reset          : clock (rising edge), synchronous active-high reset
//   num_valid           : keypad finished entering a number
//   op_valid, op_in     : operator key pressed, operator code
//   eq_valid            : equals key
//   clr_key             : clear key (highest priority)
//   load_number/clear_number : input-register strobes
//   inSelect            : ALU mux select (0 = input register, 1 = ALU result)
//   load_result/clear_result : ACC strobes
//   load_code/clear_code     : opcode-register strobes
//   OpCode              : latched operator
//   sel_display         : display mux select (0 = input register, 1 = ACC)
//   ready               : a key event is accepted this cycle
// -----------------------------------------------------------------------------
module calc_control_unit
  import calc_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 num_valid,
  input  logic                 op_valid,
  input  logic [CALC_OP_W-1:0] op_in,
  input  logic                 eq_valid,
  input  logic                 clr_key,
  output logic                 load_number,
  output logic                 clear_number,
  output logic                 inSelect,
  output logic                 load_result,
  output logic                 clear_result,
  output logic                 load_code,
  output logic                 clear_code,
  output logic [CALC_OP_W-1:0] OpCode,
  output logic                 sel_display,
  output logic                 ready
);

  localparam int                CNT_W    = $clog2(EXEC_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

  calc_state_t          state_q, state_d;
  logic [CALC_OP_W-1:0] op_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 capture_op;

  assign OpCode = op_q;

  // ---------------------------------------------------------------------------
  // State, operator and exec-counter registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLR;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (clr_key) begin
        op_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (capture_op) op_q <= op_in;
        if (state_q == S_WAIT_EQ && eq_valid) begin
          cnt_q <= '0;
        end else if (state_q == S_EXEC) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and Moore output decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    capture_op   = 1'b0;
    load_number  = 1'b0;
    clear_number = 1'b0;
    inSelect     = 1'b0;
    load_result  = 1'b0;
    clear_result = 1'b0;
    load_code    = 1'b0;
    clear_code   = 1'b0;
    sel_display  = 1'b0;
    ready        = 1'b0;

    unique case (state_q)
      S_CLR: begin
        clear_number = 1'b1;
        clear_result = 1'b1;
        clear_code   = 1'b1;
        state_d      = S_IDLE;
      end
      S_IDLE: begin
        ready = 1'b1;
        if (num_valid) state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        load_number = 1'b1;
        state_d     = S_XFER_A;
      end
      S_XFER_A: begin
        // inSelect stays 0: ACC takes the operand straight from the input register.
        load_result = 1'b1;
        state_d     = S_WAIT_OP;
      end
      S_WAIT_OP: begin
        ready = 1'b1;
        if (op_valid) begin
          capture_op = 1'b1;
          state_d    = S_LOAD_OP;
        end
      end
      S_LOAD_OP: begin
        load_code = 1'b1;
        state_d   = S_WAIT_B;
      end
      S_WAIT_B: begin
        ready = 1'b1;
        if (num_valid) state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        load_number = 1'b1;
        state_d     = S_WAIT_EQ;
      end
      S_WAIT_EQ: begin
        ready = 1'b1;
        if (eq_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        inSelect = 1'b1;
        if (cnt_q == CNT_LAST) begin
          load_result = 1'b1;
          state_d     = S_SHOW;
        end
      end
      S_SHOW: begin
        sel_display = 1'b1;
        ready       = 1'b1;
        // A new number wins over a simultaneous operator.
        if (num_valid) begin
          state_d = S_LOAD_A;
        end
`ifdef CALC_CHAIN_EN
        else if (op_valid) begin
          capture_op = 1'b1;
          state_d    = S_LOAD_OP;
        end
`endif
      end
      default: state_d = S_CLR;
    endcase

    // Clear overrides whatever the state decided; in CLR itself it is a no-op.
    if (clr_key && state_q != S_CLR) state_d = S_CLR;
  end

endmodule

// File: tb/tb_calc_control_unit.sv
// -----------------------------------------------------------------------------
// tb_calc_control_unit
// Two instances (EXEC_CYCLES = 1 and 4) share one directed key stream. A
// schedule-based model predicts each cycle's outputs: an accepted key pushes
// the strobe pattern of the following cycles into a queue, and when the queue
// drains the block rests waiting for the next expected key. Literal checks
// pin the model at the points called out for the design.
// -----------------------------------------------------------------------------
module tb_calc_control_unit;

  // clr_n, clr_r, clr_c, ld_n, ld_r, ld_c, in_sel, sel_disp, rdy
  typedef struct packed {
    logic clr_n;
    logic clr_r;
    logic clr_c;
    logic ld_n;
    logic ld_r;
    logic ld_c;
    logic in_sel;
    logic sel_disp;
    logic rdy;
  } obs_t;

  localparam obs_t V_CLR  = 9'b111_000_000;
  localparam obs_t V_LN   = 9'b000_100_000;
  localparam obs_t V_LR   = 9'b000_010_000;
  localparam obs_t V_LC   = 9'b000_001_000;
  localparam obs_t V_EX   = 9'b000_000_100;
  localparam obs_t V_EXL  = 9'b000_010_100;
  localparam obs_t V_RDY  = 9'b000_000_001;
  localparam obs_t V_SHOW = 9'b000_000_011;

`ifdef CALC_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  typedef enum {AW_NUM_A, AW_OP, AW_NUM_B, AW_EQ, AW_SHOW} await_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       num_valid, op_valid, eq_valid, clr_key;
  logic [2:0] op_in;

  logic       d1_ln, d1_cn, d1_is, d1_lr, d1_cr, d1_lc, d1_cc, d1_sd, d1_rdy;
  logic [2:0] d1_op;
  logic       d4_ln, d4_cn, d4_is, d4_lr, d4_cr, d4_lc, d4_cc, d4_sd, d4_rdy;
  logic [2:0] d4_op;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  calc_control_unit #(.EXEC_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .num_valid(num_valid), .op_valid(op_valid),
    .op_in(op_in), .eq_valid(eq_valid), .clr_key(clr_key),
    .load_number(d1_ln), .clear_number(d1_cn), .inSelect(d1_is),
    .load_result(d1_lr), .clear_result(d1_cr), .load_code(d1_lc),
    .clear_code(d1_cc), .OpCode(d1_op), .sel_display(d1_sd), .ready(d1_rdy)
  );

  calc_control_unit #(.EXEC_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .num_valid(num_valid), .op_valid(op_valid),
    .op_in(op_in), .eq_valid(eq_valid), .clr_key(clr_key),
    .load_number(d4_ln), .clear_number(d4_cn), .inSelect(d4_is),
    .load_result(d4_lr), .clear_result(d4_cr), .load_code(d4_lc),
    .clear_code(d4_cc), .OpCode(d4_op), .sel_display(d4_sd), .ready(d4_rdy)
  );

  obs_t       dut_obs [2];
  logic [2:0] dut_op  [2];
  assign dut_obs[0] = {d1_cn, d1_cr, d1_cc, d1_ln, d1_lr, d1_lc, d1_is, d1_sd, d1_rdy};
  assign dut_obs[1] = {d4_cn, d4_cr, d4_cc, d4_ln, d4_lr, d4_lc, d4_is, d4_sd, d4_rdy};
  assign dut_op[0]  = d1_op;
  assign dut_op[1]  = d4_op;

  // ---------------------------------------------------------------------------
  // Model: expected outputs of the current cycle per instance.
  // ---------------------------------------------------------------------------
  obs_t       cur    [2];
  obs_t       pend   [2][$];
  await_t     aw     [2];
  logic [2:0] exp_op [2];

  initial begin
    int   n;
    obs_t nxt;
    for (int k = 0; k < 2; k++) begin
      cur[k]    = V_CLR;
      aw[k]     = AW_NUM_A;
      exp_op[k] = 3'd0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        n = (k == 0) ? 1 : 4;
        if (reset || (clr_key && !cur[k].clr_n)) begin
          pend[k].delete();
          aw[k]     = AW_NUM_A;
          exp_op[k] = 3'd0;
          nxt       = V_CLR;
        end else begin
          if (cur[k].rdy) begin
            case (aw[k])
              AW_NUM_A: if (num_valid) begin
                pend[k].push_back(V_LN); pend[k].push_back(V_LR); aw[k] = AW_OP;
              end
              AW_OP: if (op_valid) begin
                pend[k].push_back(V_LC); exp_op[k] = op_in; aw[k] = AW_NUM_B;
              end
              AW_NUM_B: if (num_valid) begin
                pend[k].push_back(V_LN); aw[k] = AW_EQ;
              end
              AW_EQ: if (eq_valid) begin
                for (int i = 0; i < n; i++) pend[k].push_back((i == n - 1) ? V_EXL : V_EX);
                aw[k] = AW_SHOW;
              end
              AW_SHOW: begin
                if (num_valid) begin
                  pend[k].push_back(V_LN); pend[k].push_back(V_LR); aw[k] = AW_OP;
                end else if (CHAIN && op_valid) begin
                  pend[k].push_back(V_LC); exp_op[k] = op_in; aw[k] = AW_NUM_B;
                end
              end
              default: ;
            endcase
          end
          if (pend[k].size() > 0) nxt = pend[k].pop_front();
          else                    nxt = (aw[k] == AW_SHOW) ? V_SHOW : V_RDY;
        end
        cur[k] = nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle compare against the model
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          n_vec++;
          if (dut_obs[k] !== cur[k] || dut_op[k] !== exp_op[k]) begin
            n_err++;
            $display("FAIL cycle_dut%0d @%0t: got strobes=%b op=%0d, expected strobes=%b op=%0d",
                     (k == 0) ? 1 : 4, $time, dut_obs[k], dut_op[k], cur[k], exp_op[k]);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Literal checks and stimulus
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input logic nv, input logic ov, input logic [2:0] oi,
                      input logic ev, input logic ck);
    num_valid = nv; op_valid = ov; op_in = oi; eq_valid = ev; clr_key = ck;
    @(negedge clk);
    num_valid = 1'b0; op_valid = 1'b0; op_in = 3'd0; eq_valid = 1'b0; clr_key = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; num_valid = 1'b0; op_valid = 1'b0; op_in = 3'd0;
    eq_valid = 1'b0; clr_key = 1'b0;

    // Reset held for three edges.
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_clear_number", d1_cn, 1);
    check("rst_clear_code",   d4_cc, 1);
    check("rst_ready",        d1_rdy, 0);
    check("rst_opcode",       d1_op, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("post_rst_clr", d4_cr, 1);
    idle(1);
    check("post_rst_ready", d1_rdy, 1);
    check("post_rst_opcode", d4_op, 0);

    // A, op=1, B, equals.
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    check("a_load_number", d1_ln, 1);
    idle(1);
    check("a_load_result", d1_lr, 1);
    check("a_insel0",      d1_is, 0);
    idle(1);
    check("wait_op_ready", d4_rdy, 1);
    step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    check("op_load_code", d1_lc, 1);
    check("op_opcode",    d1_op, 1);
    idle(1);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    check("b_load_number", d4_ln, 1);
    idle(1);
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    check("x1_insel",   d1_is, 1);
    check("x1_ldres",   d1_lr, 1);
    check("x4_c1_insel", d4_is, 1);
    check("x4_c1_ldres", d4_lr, 0);
    idle(1);
    check("x1_show",     d1_sd, 1);
    check("x4_c2_insel", d4_is, 1);
    idle(2);
    check("x4_c4_ldres", d4_lr, 1);
    idle(1);
    check("x4_show",     d4_sd, 1);

    // Operator while on display.
    step(1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    check("show_op_load_code", d1_lc, CHAIN ? 3'd1 : 3'd0);
    check("show_op_opcode",    d4_op, CHAIN ? 3'd2 : 3'd1);
    check("show_op_display",   d4_sd, CHAIN ? 3'd0 : 3'd1);
    idle(1);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    check("clr_clear", d1_cn, 1);
    idle(1);

    // Unexpected keys in WAIT_OP; operator in WAIT_B.
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    check("wop_num_ignored", d1_ln, 0);
    check("wop_num_ready",   d1_rdy, 1);
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    check("wop_eq_ignored",  d4_is, 0);
    step(1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    check("op3_opcode", d4_op, 3);
    idle(1);
    step(1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
    check("wb_op_ignored", d1_op, 3);
    check("wb_no_ldcode",  d1_lc, 0);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(1);

    // Clear during the second EXEC cycle.
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    idle(1);
    check("abort_c2_insel", d4_is, 1);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    check("abort_clear",  d4_cn, 1);
    check("abort_noldres", d4_lr, 0);
    check("abort_opcode", d4_op, 0);
    idle(1);
    check("abort_idle", d4_rdy, 1);

    // num and op together while on display: the number wins.
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    idle(4);
    step(1'b1, 1'b1, 3'd7, 1'b0, 1'b0);
    check("both_load_number", d1_ln, 1);
    check("both_no_ldcode",   d4_lc, 0);
    check("both_opcode",      d4_op, 5);
    idle(2);

    // Reset mid-operation in WAIT_OP.
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("mid_rst_clear",   d1_cc, 1);
    check("mid_rst_noldres", d1_lr, 0);
    check("mid_rst_opcode",  d1_op, 0);
    idle(1);
    check("mid_rst_idle", d1_rdy, 1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
